// File: rtl/mem_store_buffer_pkg.sv
// rtl/mem_store_buffer_pkg.sv - access widths, data memory size and width helpers for mem_store_buffer
`ifndef DATA_MEM_SIZE
`define DATA_MEM_SIZE 1024
`endif

package mem_store_buffer_pkg;

  localparam logic [1:0] WIDTH_BYTE = 2'b00;
  localparam logic [1:0] WIDTH_HALF = 2'b01;
  localparam logic [1:0] WIDTH_WORD = 2'b10;
  localparam logic [1:0] WIDTH_BAD  = 2'b11;

  localparam int unsigned DATA_MEM_SIZE = `DATA_MEM_SIZE;

  function automatic logic [2:0] size_from_width(input logic [1:0] width);
    case (width)
      WIDTH_BYTE: return 3'd1;
      WIDTH_HALF: return 3'd2;
      default:    return 3'd4;
    endcase
  endfunction

  // Right-justified store data re-read as a load of the same width.
  function automatic logic [31:0] extend_load(input logic [31:0] data, input logic [1:0] width,
                                              input logic sign);
    case (width)
      WIDTH_BYTE: return {{24{sign & data[7]}}, data[7:0]};
      WIDTH_HALF: return {{16{sign & data[15]}}, data[15:0]};
      default:    return data;
    endcase
  endfunction

endpackage

// File: rtl/store_buf_match.sv
// rtl/store_buf_match.sv - per-entry byte-range overlap and exact address/width match against a load
module store_buf_match
  import mem_store_buffer_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              i_valid,
  input  logic [ADDR_W-1:0] i_ent_addr,
  input  logic [1:0]        i_ent_width,
  input  logic [ADDR_W-1:0] i_ld_addr,
  input  logic [1:0]        i_ld_width,
  output logic              o_overlap,
  output logic              o_exact
);

  logic [ADDR_W:0] w_ent_last;
  logic [ADDR_W:0] w_ld_last;

  // One extra bit so a range ending at the top of the address space cannot wrap.
  assign w_ent_last = {1'b0, i_ent_addr} + (ADDR_W+1)'(size_from_width(i_ent_width) - 3'd1);
  assign w_ld_last  = {1'b0, i_ld_addr} + (ADDR_W+1)'(size_from_width(i_ld_width) - 3'd1);

  assign o_overlap = i_valid && ({1'b0, i_ent_addr} <= w_ld_last) && ({1'b0, i_ld_addr} <= w_ent_last);
  assign o_exact   = (i_ent_addr == i_ld_addr) && (i_ent_width == i_ld_width);

endmodule

// File: rtl/mem_store_buffer.sv
// rtl/mem_store_buffer.sv - posted-write store FIFO ahead of the data memory write port with load hazard checks
// STORE_FWD_EN: forward exact-match queued store data to loads instead of stalling.
module mem_store_buffer
  import mem_store_buffer_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PTR_W  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              st_valid,
  output logic              st_ready,
  input  logic [ADDR_W-1:0] st_addr,
  input  logic [31:0]       st_data,
  input  logic [1:0]        st_width,
  input  logic              ld_valid,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [1:0]        ld_width,
  input  logic              ld_sign,
  output logic              ld_stall,
  output logic              ld_fwd_hit,
  output logic [31:0]       ld_fwd_data,
  input  logic              drain_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [1:0]        mem_width,
  output logic              st_err,
  output logic [PTR_W:0]    sb_count
);

  logic [ADDR_W-1:0] r_addr  [DEPTH];
  logic [31:0]       r_data  [DEPTH];
  logic [1:0]        r_width [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [1:0]        r_mem_width;
  logic              r_st_err;

  logic [2:0]        w_st_size;
  logic [ADDR_W:0]   w_st_last;
  logic              w_st_bad;
  logic              w_push_acc;
  logic              w_push_ok;
  logic              w_pop;
  logic [DEPTH-1:0]  w_ent_valid;
  logic [DEPTH-1:0]  w_overlap;
  logic [DEPTH-1:0]  w_exact;

  assign st_ready = (r_count != (PTR_W+1)'(DEPTH));

  assign w_st_size = size_from_width(st_width);
  assign w_st_last = {1'b0, st_addr} + (ADDR_W+1)'(w_st_size - 3'd1);
  assign w_st_bad  = (st_width == WIDTH_BAD)
                  || ((st_width == WIDTH_HALF) && st_addr[0])
                  || ((st_width == WIDTH_WORD) && (st_addr[1:0] != 2'b00))
                  || (w_st_last >= (ADDR_W+1)'(DATA_MEM_SIZE));

  assign w_push_acc = st_valid && st_ready;
  assign w_push_ok  = w_push_acc && !w_st_bad;
  assign w_pop      = drain_en && (r_count != '0);

  always_ff @(posedge clk) begin
    if (w_push_ok) begin
      r_addr[r_tail]  <= st_addr;
      r_data[r_tail]  <= st_data;
      r_width[r_tail] <= st_width;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_head      <= '0;
      r_tail      <= '0;
      r_count     <= '0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      r_mem_width <= '0;
      r_st_err    <= 1'b0;
    end else begin
      r_st_err <= w_push_acc && w_st_bad;
      r_mem_we <= w_pop;
      if (w_push_ok) r_tail <= r_tail + PTR_W'(1);
      if (w_pop) begin
        r_head      <= r_head + PTR_W'(1);
        r_mem_addr  <= r_addr[r_head];
        r_mem_wdata <= r_data[r_head];
        r_mem_width <= r_width[r_head];
      end
      case ({w_push_ok, w_pop})
        2'b10:   r_count <= r_count + (PTR_W+1)'(1);
        2'b01:   r_count <= r_count - (PTR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Slot g is occupied when its distance from head is below the count.
  for (genvar g = 0; g < DEPTH; g++) begin : g_match
    logic [PTR_W-1:0] w_age;
    assign w_age          = PTR_W'(g) - r_head;
    assign w_ent_valid[g] = ({1'b0, w_age} < r_count);

    store_buf_match #(.ADDR_W(ADDR_W)) u_match (
      .i_valid    (w_ent_valid[g]),
      .i_ent_addr (r_addr[g]),
      .i_ent_width(r_width[g]),
      .i_ld_addr  (ld_addr),
      .i_ld_width (ld_width),
      .o_overlap  (w_overlap[g]),
      .o_exact    (w_exact[g])
    );
  end

`ifdef STORE_FWD_EN
  logic [PTR_W-1:0] w_idx;
  logic [PTR_W-1:0] w_sel;
  logic             w_any;
  logic             w_hit;

  // Walk oldest to youngest so the last overlapping slot seen wins.
  always_comb begin
    w_sel = r_head;
    w_idx = r_head;
    w_any = 1'b0;
    for (int a = 0; a < DEPTH; a++) begin
      w_idx = r_head + PTR_W'(a);
      if (w_overlap[w_idx]) begin
        w_sel = w_idx;
        w_any = 1'b1;
      end
    end
  end

  assign w_hit       = ld_valid && w_any && w_exact[w_sel];
  assign ld_stall    = ld_valid && w_any && !w_exact[w_sel];
  assign ld_fwd_hit  = w_hit;
  assign ld_fwd_data = w_hit ? extend_load(r_data[w_sel], ld_width, ld_sign) : 32'd0;
`else
  logic w_unused;
  assign w_unused    = ^{ld_sign, w_exact};
  assign ld_stall    = ld_valid && (|w_overlap);
  assign ld_fwd_hit  = 1'b0;
  assign ld_fwd_data = 32'd0;
`endif

  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign mem_width = r_mem_width;
  assign st_err    = r_st_err;
  assign sb_count  = r_count;

endmodule

// File: tb/tb_mem_store_buffer.sv
// tb/tb_mem_store_buffer.sv - queue-model and directed-vector bench for mem_store_buffer
module tb_mem_store_buffer;
  import mem_store_buffer_pkg::*;

  localparam int DEPTH = 4;
`ifdef STORE_FWD_EN
  localparam bit FWD = 1'b1;
`else
  localparam bit FWD = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset_n;
  logic        st_valid, st_ready;
  logic [31:0] st_addr, st_data;
  logic [1:0]  st_width;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [1:0]  ld_width;
  logic        ld_sign;
  logic        ld_stall, ld_fwd_hit;
  logic [31:0] ld_fwd_data;
  logic        drain_en;
  logic        mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_width;
  logic        st_err;
  logic [2:0]  sb_count;

  int n_err = 0;
  int n_chk = 0;

  mem_store_buffer #(.DEPTH(4), .PTR_W(2), .ADDR_W(32)) dut (
    .clk(clk), .reset_n(reset_n),
    .st_valid(st_valid), .st_ready(st_ready), .st_addr(st_addr), .st_data(st_data), .st_width(st_width),
    .ld_valid(ld_valid), .ld_addr(ld_addr), .ld_width(ld_width), .ld_sign(ld_sign),
    .ld_stall(ld_stall), .ld_fwd_hit(ld_fwd_hit), .ld_fwd_data(ld_fwd_data),
    .drain_en(drain_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_width(mem_width), .st_err(st_err), .sb_count(sb_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_chk++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got %h want %h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [1:0]  width;
  } ent_t;

  ent_t        q[$];
  logic        e_we = 0, e_err = 0;
  logic [31:0] e_addr = 0, e_wdata = 0;
  logic [1:0]  e_width = 0;

  function automatic int nbytes(input logic [1:0] w);
    return (w == 2'b00) ? 1 : (w == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit legal(input logic [31:0] a, input logic [1:0] w);
    if (w == 2'b11) return 0;
    if ((a % nbytes(w)) != 0) return 0;
    if (longint'(a) + nbytes(w) > longint'(DATA_MEM_SIZE)) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] ext(input logic [31:0] d, input logic [1:0] w, input logic s);
    logic [31:0] v;
    if (w == 2'b00) begin v = d & 32'hFF;   if (s && d[7])  v = v | 32'hFFFF_FF00; end
    else if (w == 2'b01) begin v = d & 32'hFFFF; if (s && d[15]) v = v | 32'hFFFF_0000; end
    else v = d;
    return v;
  endfunction

  always @(posedge clk or negedge reset_n) begin : model
    bit acc;
    if (!reset_n) begin
      q.delete();
      e_we = 0; e_addr = 0; e_wdata = 0; e_width = 0; e_err = 0;
    end else begin
      acc = st_valid && (q.size() < DEPTH);
      if (drain_en && q.size() != 0) begin
        e_we = 1; e_addr = q[0].addr; e_wdata = q[0].data; e_width = q[0].width;
        void'(q.pop_front());
      end else e_we = 0;
      e_err = 0;
      if (acc) begin
        if (legal(st_addr, st_width)) q.push_back('{st_addr, st_data, st_width});
        else e_err = 1;
      end
    end
  end

  task automatic exp_load(output logic stall, output logic hit, output logic [31:0] data);
    int y;
    longint ls, le, es, ee;
    stall = 0; hit = 0; data = 0; y = -1;
    ls = longint'(ld_addr);
    le = ls + nbytes(ld_width) - 1;
    foreach (q[i]) begin
      es = longint'(q[i].addr);
      ee = es + nbytes(q[i].width) - 1;
      if (es <= le && ls <= ee) y = i;
    end
    if (!ld_valid || y < 0) return;
    if (FWD && q[y].addr == ld_addr && q[y].width == ld_width) begin
      hit = 1; data = ext(q[y].data, ld_width, ld_sign);
    end else stall = 1;
  endtask

  always @(negedge clk) begin : compare
    logic s, h;
    logic [31:0] d;
    exp_load(s, h, d);
    chk("st_ready", st_ready, q.size() < DEPTH);
    chk("sb_count", sb_count, q.size());
    chk("mem_we", mem_we, e_we);
    chk("mem_addr", mem_addr, e_addr);
    chk("mem_wdata", mem_wdata, e_wdata);
    chk("mem_width", mem_width, e_width);
    chk("st_err", st_err, e_err);
    chk("ld_stall", ld_stall, s);
    chk("ld_fwd_hit", ld_fwd_hit, h);
    chk("ld_fwd_data", ld_fwd_data, d);
  end

  // ---------------- directed stimulus ----------------
  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] w);
    st_valid = 1; st_addr = a; st_data = d; st_width = w;
    cycle();
    st_valid = 0;
  endtask

  task automatic ld_try(input string name, input logic [31:0] a, input logic [1:0] w, input logic s,
                        input logic xs, input logic xh, input logic [31:0] xd);
    ld_valid = 1; ld_addr = a; ld_width = w; ld_sign = s;
    #1;
    chk({name, "_stall"}, ld_stall, xs);
    chk({name, "_hit"}, ld_fwd_hit, xh);
    chk({name, "_data"}, ld_fwd_data, xd);
    cycle();
  endtask

  typedef struct { logic [31:0] a; logic [1:0] w; logic err; } bvec_t;
  bvec_t bvec[6];

  initial begin
    reset_n = 0; st_valid = 0; st_addr = 0; st_data = 0; st_width = 0;
    ld_valid = 0; ld_addr = 0; ld_width = 0; ld_sign = 0; drain_en = 0;
    #12;
    chk("rst_mem_we", mem_we, 0);
    chk("rst_sb_count", sb_count, 0);
    chk("rst_st_ready", st_ready, 1);
    chk("rst_st_err", st_err, 0);
    cycle();
    reset_n = 1;
    cycle();

    // 1: single word store, drained as soon as possible
    drain_en = 1;
    push(32'h10, 32'hDEADBEEF, WIDTH_WORD);
    chk("t1_count_after_push", sb_count, 1);
    chk("t1_we_at_push", mem_we, 0);
    cycle();
    chk("t1_we", mem_we, 1);
    chk("t1_addr", mem_addr, 32'h10);
    chk("t1_wdata", mem_wdata, 32'hDEADBEEF);
    chk("t1_width", mem_width, 2'b10);
    cycle();
    chk("t1_we_drop", mem_we, 0);
    chk("t1_addr_hold", mem_addr, 32'h10);

    // 2: fill to full, attempt an extra push, then drain in order
    drain_en = 0;
    for (int i = 0; i < 4; i++) push(32'h40 + 32'(4 * i), 32'h1000 + 32'(i), WIDTH_WORD);
    chk("t2_full_count", sb_count, 4);
    chk("t2_full_ready", st_ready, 0);
    push(32'h80, 32'h9999, WIDTH_WORD);
    chk("t2_full_nopush", sb_count, 4);
    chk("t2_full_noerr", st_err, 0);
    drain_en = 1;
    for (int i = 0; i < 4; i++) begin
      cycle();
      chk("t2_pop_we", mem_we, 1);
      chk("t2_pop_addr", mem_addr, 32'h40 + 32'(4 * i));
      chk("t2_pop_data", mem_wdata, 32'h1000 + 32'(i));
      if (i == 0) chk("t2_ready_after_pop", st_ready, 1);
    end
    cycle();
    chk("t2_empty_we", mem_we, 0);

    // 3: rejected stores and memory-size boundary
    push(32'h11, 32'hAAAA, WIDTH_HALF);
    chk("t3_half_err", st_err, 1);
    chk("t3_half_count", sb_count, 0);
    cycle();
    chk("t3_err_pulse", st_err, 0);
    chk("t3_no_we", mem_we, 0);
    push(32'h0E, 32'hBBBB_BBBB, WIDTH_WORD);
    chk("t3_word_err", st_err, 1);
    chk("t3_word_count", sb_count, 0);
    drain_en = 0;
    bvec[0] = '{32'h3FC, WIDTH_WORD, 1'b0};
    bvec[1] = '{32'h400, WIDTH_WORD, 1'b1};
    bvec[2] = '{32'h3FF, WIDTH_BYTE, 1'b0};
    bvec[3] = '{32'h3FE, WIDTH_HALF, 1'b0};
    bvec[4] = '{32'h3FF, WIDTH_HALF, 1'b1};
    bvec[5] = '{32'h010, WIDTH_BAD,  1'b1};
    foreach (bvec[i]) begin
      push(bvec[i].a, 32'h77, bvec[i].w);
      chk("t3_bound_err", st_err, bvec[i].err);
    end
    chk("t3_bound_count", sb_count, 3);
    drain_en = 1;
    repeat (4) cycle();
    chk("t3_drained", sb_count, 0);

    // 4: word queued, loads against it
    drain_en = 0;
    push(32'h20, 32'h80FF1234, WIDTH_WORD);
    ld_try("t4_half", 32'h20, WIDTH_HALF, 1, 1, 0, 32'h0);
    ld_try("t4_word", 32'h20, WIDTH_WORD, 1, !FWD, FWD, FWD ? 32'h80FF1234 : 32'h0);
    ld_try("t4_adjacent", 32'h24, WIDTH_BYTE, 0, 0, 0, 32'h0);
    ld_valid = 1; ld_addr = 32'h20; ld_width = WIDTH_HALF; ld_sign = 1;
    cycle();
    chk("t4_still_stall", ld_stall, 1);
    drain_en = 1;
    cycle();
    chk("t4_released", ld_stall, 0);
    ld_valid = 0;

    // 5: byte queued, wider and narrower loads
    drain_en = 0;
    push(32'h23, 32'hDA, WIDTH_BYTE);
    ld_try("t5_word", 32'h20, WIDTH_WORD, 0, 1, 0, 32'h0);
    ld_try("t5_byte_below", 32'h22, WIDTH_BYTE, 0, 0, 0, 32'h0);
    ld_try("t5_half", 32'h22, WIDTH_HALF, 0, 1, 0, 32'h0);
    ld_try("t5_byte_exact", 32'h23, WIDTH_BYTE, 1, !FWD, FWD, FWD ? 32'hFFFF_FFDA : 32'h0);
    ld_valid = 1; ld_addr = 32'h20; ld_width = WIDTH_WORD; ld_sign = 0;
    drain_en = 1;
    #1;
    chk("t5_stall_before_pop", ld_stall, 1);
    cycle();
    chk("t5_stall_released", ld_stall, 0);
    ld_valid = 0;

    // 6: reset mid-drain with entries queued
    drain_en = 0;
    for (int i = 0; i < 4; i++) push(32'h60 + 32'(4 * i), 32'h600 + 32'(i), WIDTH_WORD);
    drain_en = 1;
    cycle();
    chk("t6_we_before_rst", mem_we, 1);
    chk("t6_count_before_rst", sb_count, 3);
    #2;
    reset_n = 0;
    #1;
    chk("t6_rst_we", mem_we, 0);
    chk("t6_rst_addr", mem_addr, 0);
    chk("t6_rst_wdata", mem_wdata, 0);
    chk("t6_rst_width", mem_width, 0);
    chk("t6_rst_count", sb_count, 0);
    chk("t6_rst_ready", st_ready, 1);
    cycle();
    cycle();
    reset_n = 1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("t6_no_we", mem_we, 0);
    end

    cycle();
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
